// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: data width, default queue depth
// and the transmit-queue state encoding.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int DEFAULT_DEPTH = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count and a flush that
// discards queued entries. Usable for either direction of the UART.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    parameter int  W     = UART_DATA_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic [W-1:0] WrData,
    input  logic         WrEn,
    input  logic         RdEn,
    input  logic         Flush,
    output logic [W-1:0] RdData,
    output logic         Full,
    output logic         Empty,
    output logic [AW:0]  Count
);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;
    logic         doPush;
    logic         doPop;

    assign Empty  = (wrPtr == rdPtr);
    assign Full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doPush = WrEn && !Full && !Flush;
    assign doPop  = RdEn && !Empty && !Flush;
    assign Count  = wrPtr - rdPtr;
    assign RdData = mem[rdPtr[AW-1:0]];

    // Flush snaps the read pointer to the pre-edge write pointer, so a push
    // arriving in the same cycle is lost along with the queued bytes.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (Flush) begin
            rdPtr <= wrPtr;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (doPush) mem[wrPtr[AW-1:0]] <= WrData;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding uart_tx: buffers host bytes and hands them over one frame
// at a time, advancing on each TxDone pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no frame owned by uart_tx; pop as soon as a byte is queued
// ST_SEND | TxEn high, TxData held; TxDone pops next byte or returns idle
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [UART_DATA_W-1:0] InData,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic                   Flush,
    output logic [UART_DATA_W-1:0] TxData,
    output logic                   TxEn,
    input  logic                   TxDone,
    output logic [AW:0]            Count,
    output logic                   Busy,
    output logic                   Overflow
);

    logic [0:0]             state;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop;
    logic [UART_DATA_W-1:0] head;

    assign InReady = !full;
    assign push    = InValid && !full;
    assign Busy    = TxEn || (Count != '0);

    always_comb begin
        pop = 1'b0;
        if (!Flush && !empty) begin
            if (state == ST_IDLE)    pop = 1'b1;
            else if (TxDone)         pop = 1'b1;
        end
    end

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (UART_DATA_W)
    ) uFifo (
        .Clk    (Clk),
        .Rst    (Rst),
        .WrData (InData),
        .WrEn   (push),
        .RdEn   (pop),
        .Flush  (Flush),
        .RdData (head),
        .Full   (full),
        .Empty  (empty),
        .Count  (Count)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= ST_IDLE;
            TxEn     <= 1'b0;
            TxData   <= '0;
            Overflow <= 1'b0;
        end else begin
            Overflow <= InValid && full;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        TxData <= head;
                        TxEn   <= 1'b1;
                        state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (TxDone) begin
                        if (pop) begin
                            TxData <= head;
                        end else begin
                            TxEn  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    TxEn  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue at DEPTH=4: vector table, directed
// corner-case sequences and a randomized run against a queue-based model.
module tb_uart_tx_queue;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  InData = '0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic        Flush = 1'b0;
    logic [7:0]  TxData;
    logic        TxEn;
    logic        TxDone = 1'b0;
    logic [AW:0] Count;
    logic        Busy;
    logic        Overflow;

    int errors = 0;
    int checks = 0;

    // reference model: queued bytes, in-flight flag/byte, overflow pulse
    logic [7:0] mq[$];
    bit         mEn;
    logic [7:0] mData;
    bit         mOvf;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         f;
        bit         dn;
        bit         eEn;
        logic [7:0] eData;
        int         eCnt;
        bit         eRdy;
        bit         eOvf;
    } vec_t;

    vec_t tbl[11];

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .InData   (InData),
        .InValid  (InValid),
        .InReady  (InReady),
        .Flush    (Flush),
        .TxData   (TxData),
        .TxEn     (TxEn),
        .TxDone   (TxDone),
        .Count    (Count),
        .Busy     (Busy),
        .Overflow (Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit f, input bit dn);
        InValid = v;
        InData  = d;
        Flush   = f;
        TxDone  = dn;
        @(posedge Clk);
        #1;
    endtask

    task automatic doReset();
        InValid = 1'b0;
        InData  = '0;
        Flush   = 1'b0;
        TxDone  = 1'b0;
        Rst     = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        mq.delete();
        mEn   = 1'b0;
        mData = '0;
        mOvf  = 1'b0;
    endtask

    task automatic modelStep(input bit v, input logic [7:0] d, input bit f, input bit dn);
        bit full;
        full = (mq.size() == DEPTH);
        mOvf = v && full;
        if (f) begin
            mq.delete();
            if (mEn && dn) mEn = 1'b0;
        end else begin
            if (!mEn || dn) begin
                if (mq.size() > 0) begin
                    mData = mq.pop_front();
                    mEn   = 1'b1;
                end else begin
                    mEn = 1'b0;
                end
            end
            if (v && !full) mq.push_back(d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got[$];
        logic [7:0] sent[$];
        int         dones;
        int         age;
        int         gaps;
        int         nextByte;
        int         maxCnt;
        bit         v;
        bit         f;
        bit         dn;
        logic [7:0] d;

        tbl[0]  = '{1, 8'h5D, 0, 0,  0, 8'h00, 1, 1, 0};
        tbl[1]  = '{0, 8'h00, 0, 0,  1, 8'h5D, 0, 1, 0};
        tbl[2]  = '{0, 8'h00, 0, 0,  1, 8'h5D, 0, 1, 0};
        tbl[3]  = '{0, 8'h00, 0, 1,  0, 8'h5D, 0, 1, 0};
        tbl[4]  = '{0, 8'h00, 0, 1,  0, 8'h5D, 0, 1, 0};
        tbl[5]  = '{1, 8'hA1, 0, 0,  0, 8'h5D, 1, 1, 0};
        tbl[6]  = '{1, 8'hA2, 0, 0,  1, 8'hA1, 1, 1, 0};
        tbl[7]  = '{1, 8'hA3, 0, 1,  1, 8'hA2, 1, 1, 0};
        tbl[8]  = '{1, 8'hA4, 1, 0,  1, 8'hA2, 0, 1, 0};
        tbl[9]  = '{0, 8'h00, 0, 1,  0, 8'hA2, 0, 1, 0};
        tbl[10] = '{0, 8'h00, 0, 0,  0, 8'hA2, 0, 1, 0};

        // reset state
        doReset();
        chk("reset_txen", TxEn, 0);
        chk("reset_txdata", TxData, 8'h00);
        chk("reset_count", Count, 0);
        chk("reset_inready", InReady, 1);
        chk("reset_busy", Busy, 0);
        chk("reset_overflow", Overflow, 0);

        // single byte, simultaneous push/pop, flush discarding a push
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].dn);
            chk($sformatf("vec%0d_txen", i), TxEn, tbl[i].eEn);
            chk($sformatf("vec%0d_txdata", i), TxData, tbl[i].eData);
            chk($sformatf("vec%0d_count", i), Count, tbl[i].eCnt);
            chk($sformatf("vec%0d_inready", i), InReady, tbl[i].eRdy);
            chk($sformatf("vec%0d_overflow", i), Overflow, tbl[i].eOvf);
            chk($sformatf("vec%0d_busy", i), Busy, int'(tbl[i].eEn || tbl[i].eCnt != 0));
        end

        // burst of four with a frame lasting 20 cycles
        doReset();
        dones = 0;
        age   = 0;
        gaps  = 0;
        for (int c = 0; c < 300 && dones < 4; c++) begin
            dn = TxEn && (age == 19);
            if (dn) begin
                got.push_back(TxData);
                dones++;
                age = 0;
            end else if (TxEn) begin
                age++;
            end
            step(c < 4, 8'(c + 1), 0, dn);
            if (c >= 1 && dones < 4 && !TxEn) gaps++;
        end
        chk("burst_done_count", dones, 4);
        chk("burst_gaps", gaps, 0);
        chk("burst_txen_off", TxEn, 0);
        chk("burst_busy_off", Busy, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("burst_byte%0d", i), (i < got.size()) ? int'(got[i]) : -1, i + 1);

        // fill to full, overflow drops 8'hAA
        doReset();
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
        chk("full_count", Count, 4);
        chk("full_inready", InReady, 0);
        chk("full_txen", TxEn, 1);
        chk("full_txdata", TxData, 8'h01);
        step(1, 8'hAA, 0, 0);
        chk("ovf_pulse", Overflow, 1);
        chk("ovf_count", Count, 4);
        step(0, 8'h00, 0, 0);
        chk("ovf_pulse_end", Overflow, 0);
        chk("ovf_count_after", Count, 4);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("ovf_drain%0d", k), TxData, k + 1);
            step(0, 8'h00, 0, 1);
            step(0, 8'h00, 0, 0);
        end
        chk("ovf_drain_txen", TxEn, 0);
        chk("ovf_drain_count", Count, 0);

        // wrap-around: 3*DEPTH+1 bytes, random TxDone cadence
        doReset();
        nextByte = 0;
        maxCnt   = 0;
        for (int c = 0; c < 3000 && sent.size() < 3 * DEPTH + 1; c++) begin
            v  = (nextByte < 3 * DEPTH + 1) && InReady;
            dn = TxEn && ($urandom_range(0, 3) == 0);
            if (dn) sent.push_back(TxData);
            step(v, 8'(8'h20 + nextByte), 0, dn);
            if (v) nextByte++;
            if (int'(Count) > maxCnt) maxCnt = int'(Count);
        end
        chk("wrap_sent_count", sent.size(), 3 * DEPTH + 1);
        for (int i = 0; i < sent.size(); i++)
            chk($sformatf("wrap_byte%0d", i), sent[i], 8'h20 + i);
        chk("wrap_count_bounded", int'(maxCnt > DEPTH), 0);

        // flush while a frame is in flight
        doReset();
        for (int i = 0; i < 4; i++) step(1, 8'(8'h10 + i), 0, 0);
        chk("flush_pre_count", Count, 3);
        chk("flush_pre_txdata", TxData, 8'h10);
        step(0, 8'h00, 1, 0);
        chk("flush_count", Count, 0);
        chk("flush_txen", TxEn, 1);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);
        chk("flush_txdata_held", TxData, 8'h10);
        step(0, 8'h00, 0, 1);
        chk("flush_done_txen", TxEn, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0);
        chk("flush_no_more_txen", TxEn, 0);
        chk("flush_no_more_busy", Busy, 0);

        // asynchronous reset between edges mid-frame
        doReset();
        step(1, 8'h55, 0, 0);
        step(0, 8'h00, 0, 0);
        step(1, 8'h66, 0, 0);
        chk("arst_pre_txen", TxEn, 1);
        #3;
        Rst = 1'b1;
        #1;
        chk("arst_txen", TxEn, 0);
        chk("arst_count", Count, 0);
        chk("arst_inready", InReady, 1);
        #2;
        Rst = 1'b0;
        InValid = 1'b0;
        step(1, 8'h3C, 0, 0);
        chk("arst_push_count", Count, 1);
        step(0, 8'h00, 0, 0);
        chk("arst_tx_txen", TxEn, 1);
        chk("arst_tx_txdata", TxData, 8'h3C);

        // randomized traffic against the reference model
        doReset();
        for (int c = 0; c < 800; c++) begin
            v  = $urandom_range(0, 1);
            d  = 8'($urandom);
            f  = ($urandom_range(0, 24) == 0);
            dn = mEn ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
            modelStep(v, d, f, dn);
            step(v, d, f, dn);
            chk("rnd_txen", TxEn, mEn);
            chk("rnd_txdata", TxData, mData);
            chk("rnd_count", Count, mq.size());
            chk("rnd_inready", InReady, int'(mq.size() != DEPTH));
            chk("rnd_busy", Busy, int'(mEn || mq.size() != 0));
            chk("rnd_overflow", Overflow, mOvf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
